// File: rtl/ram_dump_tx_if.sv
//==============================================================================
// Module  : ram_dump_tx_if
// Brief   : Control, RAM read port and serial line bundle for ram_dump_tx.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface ram_dump_tx_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              start;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_data;
    logic              uart_tx;
    logic              busy;
    logic              done;

    modport master (
        output start, last_addr, mem_data,
        input  mem_addr, uart_tx, busy, done
    );

    modport slave (
        input  start, last_addr, mem_data,
        output mem_addr, uart_tx, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/ram_dump_tx.sv
//==============================================================================
// Module  : ram_dump_tx
// Brief   : Streams RAM words 0..last_addr out of an 8N1 UART, high byte first.
// Revision: 1.0
//==============================================================================
`default_nettype none

module ram_dump_tx #(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 256,
    parameter int CLKS_PER_BIT = 234
) (
    input  logic          clk,
    input  logic          rst,
    ram_dump_tx_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_STOP   = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [WIDTH-1:0]  r_word;
    logic              r_hi;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_last;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;
    logic              w_tx;
    logic              w_baud_end;
    logic              w_accept;
    logic [7:0]        w_byte;

    assign w_baud_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    // busy is still high in the cycle after done, so a held start waits one more cycle
    assign w_accept   = (r_state == S_IDLE) && bus.start && !r_busy;
    assign w_byte     = r_hi ? r_word[WIDTH-1 -: 8] : r_word[7:0];

    assign bus.mem_addr = r_addr;
    assign bus.uart_tx  = r_tx;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_tx   = 1'b1;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_FETCH;
            S_FETCH:  w_next = S_WAIT;
            S_WAIT:   w_next = S_START;
            S_START: begin
                w_tx = 1'b0;
                if (w_baud_end) w_next = S_DATA;
            end
            S_DATA: begin
                w_tx = w_byte[r_bit];
                if (w_baud_end && (r_bit == 3'd7)) w_next = S_STOP;
            end
            S_STOP: begin
                if (w_baud_end) begin
                    if (r_hi)                 w_next = S_START;
                    else if (r_addr == r_last) w_next = S_FINISH;
                    else                      w_next = S_FETCH;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // The line and done are registered copies of the state decode, one cycle behind the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_addr <= '0;
            r_last <= '0;
            r_baud <= '0;
            r_bit  <= '0;
            r_word <= '0;
            r_hi   <= 1'b0;
        end else begin
            r_tx   <= w_tx;
            r_done <= (r_state == S_FINISH);
            if (r_done) r_busy <= 1'b0;

            if ((r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP))
                r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
            else
                r_baud <= '0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_last <= bus.last_addr;
                        r_addr <= '0;
                        r_busy <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_word <= bus.mem_data;
                    r_hi   <= 1'b1;
                    r_bit  <= '0;
                end
                S_DATA: begin
                    if (w_baud_end) r_bit <= r_bit + 3'd1;
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        if (r_hi)                  r_hi   <= 1'b0;
                        else if (r_addr != r_last) r_addr <= r_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_ram_dump_tx.sv
//==============================================================================
// Module  : tb_ram_dump_tx
// Brief   : Scoreboard bench for ram_dump_tx: UART decode, gaps, latency, reset.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_ram_dump_tx;
    localparam int CPB    = 4;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = $clog2(DEPTH);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [15:0] mem [DEPTH];
    logic [7:0]  sb_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    int          rst_gen  = 0;

    ram_dump_tx_if #(.WIDTH(16), .DEPTH(DEPTH)) bus ();

    ram_dump_tx #(.WIDTH(16), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM model
    always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin : done_counter
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
        end
    end

    // Frame decoder: samples mid-bit and compares {stop, byte, start} to the scoreboard
    initial begin : uart_mon
        int         gen;
        logic [9:0] frame;
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (bus.uart_tx === 1'b0) begin
                gen = rst_gen;
                repeat (CPB / 2) @(negedge clk);
                frame[0] = bus.uart_tx;
                for (int b = 1; b < 10; b++) begin
                    repeat (CPB) @(negedge clk);
                    frame[b] = bus.uart_tx;
                end
                if (gen == rst_gen) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_extra_byte", 32'd1, 32'd0);
                    end else begin
                        exp = sb_q.pop_front();
                        chk("uart_frame", {22'd0, frame}, {22'd0, 1'b1, exp, 1'b0});
                    end
                end
            end
        end
    end

    // Frame-start spacing: back to back within a word, two extra idle cycles between words
    initial begin : gap_mon
        int   frame_idx;
        int   since;
        logic prev_tx;
        frame_idx = 0;
        since     = 0;
        prev_tx   = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.busy !== 1'b1) begin
                frame_idx = 0;
                since     = 0;
            end else if (prev_tx === 1'b1 && bus.uart_tx === 1'b0 &&
                         (frame_idx == 0 || since >= 10 * CPB)) begin
                if (frame_idx > 0)
                    chk("frame_spacing", since, (frame_idx % 2 == 1) ? 10 * CPB : 10 * CPB + 2);
                frame_idx++;
                since = 1;
            end else begin
                since++;
            end
            prev_tx = bus.uart_tx;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic push_word(input int a);
        sb_q.push_back(mem[a][15:8]);
        sb_q.push_back(mem[a][7:0]);
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            #1;
        end while (bus.done !== 1'b1 && cyc < limit);
    endtask

    task automatic run_dump(input int last);
        int cyc;
        int exp_cyc;
        int d0;
        for (int i = 0; i <= last; i++) push_word(i);
        exp_cyc = (last + 1) * 20 * CPB + last * 2 + 3;
        d0 = done_cnt;
        @(negedge clk);
        bus.last_addr = ADDR_W'(last);
        bus.start     = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk("busy_rise", bus.busy, 1);
        chk("addr_start", bus.mem_addr, 0);
        wait_done(exp_cyc + 50, cyc);
        chk("done_latency", cyc, exp_cyc);
        @(posedge clk);
        #1;
        chk("done_width", bus.done, 0);
        chk("busy_fall", bus.busy, 0);
        chk("addr_final", bus.mem_addr, last);
        chk("done_count", done_cnt - d0, 1);
    endtask

    initial begin : stim
        int cyc;
        int d0;
        bus.start     = 1'b0;
        bus.last_addr = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", bus.uart_tx, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_addr", bus.mem_addr, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single word
        mem[0] = 16'hA55A;
        run_dump(0);

        // Multi-word
        for (int i = 0; i < 4; i++) mem[i] = 16'h0100 + 16'(i);
        run_dump(3);

        // Full range
        for (int i = 0; i < DEPTH; i++) mem[i] = {~8'(i), 8'(i)};
        run_dump(DEPTH - 1);

        // Start re-pulsed mid-dump, last_addr changed while busy, then start held high
        d0 = done_cnt;
        push_word(0);
        push_word(1);
        @(negedge clk);
        bus.last_addr = ADDR_W'(1);
        bus.start     = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 20) begin
                bus.last_addr = '0;
                bus.start     = 1'b1;
            end
            if (cyc == 21) bus.start = 1'b0;
            if (cyc == 100) begin
                bus.start = 1'b1;
                push_word(0);
            end
        end while (bus.done !== 1'b1 && cyc < 400);
        chk("hold_first_latency", cyc, 2 * 20 * CPB + 2 + 3);
        @(posedge clk);
        #1 chk("hold_busy_gap", bus.busy, 0);
        @(posedge clk);
        #1 chk("hold_restart", bus.busy, 1);
        bus.start = 1'b0;
        wait_done(200, cyc);
        chk("hold_second_latency", cyc, 20 * CPB + 3);
        @(posedge clk);
        #1;
        chk("hold_done_count", done_cnt - d0, 2);
        chk("hold_addr_final", bus.mem_addr, 0);

        // Reset during the data bits of the second byte
        d0 = done_cnt;
        push_word(0);
        push_word(1);
        @(negedge clk);
        bus.last_addr = ADDR_W'(1);
        bus.start     = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        rst_gen++;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_tx", bus.uart_tx, 1);
        chk("midrst_busy", bus.busy, 0);
        repeat (60) @(posedge clk);
        #1 chk("midrst_no_done", done_cnt - d0, 0);
        sb_q.delete();
        run_dump(1);

        // Start and reset together
        @(negedge clk);
        bus.start = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        rst       = 1'b0;
        chk("startrst_busy", bus.busy, 0);
        chk("startrst_tx", bus.uart_tx, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("startrst_idle", bus.busy, 0);
        chk("startrst_line", bus.uart_tx, 1);

        repeat (CPB * 12) @(posedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/ram_dump_tx.md
# ram_dump_tx

Reads a contiguous range of 16-bit words out of the program RAM and sends them over a UART TX line, high byte first, two bytes per word. This is the readback path that pairs with the UART program loader: a host streams a program in, then triggers a dump to check RAM contents. The block owns the RAM read port only while `busy` is high, and it contains its own baud-rate generator and 8N1 serializer.

## Interface
- `WIDTH`, 16: memory word width; fixed at 16 (two bytes per word).
- `DEPTH`, 256: number of memory words; address width is `$clog2(DEPTH)`.
- `CLKS_PER_BIT`, 234: `clk` cycles per UART bit; must be ≥ 2.

- `clk` in 1: single system clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: dump request, sampled only in IDLE.
- `last_addr` in `$clog2(DEPTH)`: final word address to dump; latched when `start` is accepted.
- `mem_addr` out `$clog2(DEPTH)`: RAM read address (registered).
- `mem_data` in `WIDTH`: RAM read data; valid exactly 1 cycle after `mem_addr` changes (synchronous read).
- `uart_tx` out 1: serial output; idles high.
- `busy` out 1: high from the cycle after `start` is accepted until the dump completes.
- `done` out 1: single-cycle pulse when the last stop bit finishes.

## Operation
- Reset values: `uart_tx`=1, `busy`=0, `done`=0, `mem_addr`=0, FSM=IDLE, baud counter=0, bit index=0.
- FSM states: IDLE → FETCH → WAIT → START → DATA → STOP → (START | FETCH | FINISH) → IDLE.
- IDLE: `uart_tx`=1. If `start`=1, latch `last_addr`, set `mem_addr`=0 and `busy`=1, then go to FETCH. A `start` that arrives while `busy`=1 is ignored and is not queued.
- FETCH: wait one cycle for the read latency.
- WAIT: capture `mem_data` into the word register, select the high byte, then go to START.
- START: drive `uart_tx`=0 for `CLKS_PER_BIT` cycles.
- DATA: send 8 bits LSB first, each held for `CLKS_PER_BIT` cycles.
- STOP: drive `uart_tx`=1 for `CLKS_PER_BIT` cycles. At the end of STOP:
  - if the high byte was just sent, select the low byte and go to START (no gap);
  - else if `mem_addr` == latched `last_addr`, go to FINISH;
  - else increment `mem_addr` and go to FETCH.
- FINISH: pulse `done`=1 for one cycle, clear `busy`, then go to IDLE.
- `mem_addr` never wraps. `last_addr`=DEPTH-1 ends the dump after address DEPTH-1. `last_addr`=0 dumps exactly one word.
- Changing `last_addr` or `mem_data` outside the capture cycles has no effect.
- `rst` asserted mid-frame: on the next edge `uart_tx`=1, `busy`=0, FSM=IDLE, and the partial frame is abandoned. `rst` wins over a simultaneous `start`.

## Timing
- `start` sampled high at edge E0: `busy`=1 and `mem_addr`=0 after E0. `mem_data` is captured at E2. `uart_tx` falls after E3.
- Each byte frame is 10 × `CLKS_PER_BIT` cycles. High and low bytes are back to back.
- Between words, the line stays high for 2 extra cycles (FETCH and WAIT) beyond the stop bit.
- A dump of N words, measured from the `uart_tx` fall to the end of the last stop bit, takes N×20×`CLKS_PER_BIT` + (N−1)×2 cycles.
- `done` is high for the one cycle after the last stop bit. `busy` falls on the same edge that `done` falls.
- The earliest next `start` is accepted the cycle after `busy`=0.

## Test plan
- Single word (`CLKS_PER_BIT`=4, `last_addr`=0, mem[0]=16'hA55A):
  - `uart_tx` decodes to bytes 8'hA5 then 8'h5A, LSB first, each with start=0 and stop=1;
  - `done` pulses once, 83 cycles after the `start` edge.
- Multi-word (`last_addr`=3, mem[i]=16'h0100+i):
  - decoded byte stream is 01 00 01 01 01 02 01 03;
  - exactly 2 idle-high cycles appear between words;
  - `mem_addr` stops at 3.
- Full range (`DEPTH`=256, `last_addr`=255, mem[i]={~i[7:0], i[7:0]}):
  - all 512 bytes are correct;
  - `mem_addr` does not wrap to 0;
  - `done` pulses once.
- `start` pulsed again mid-dump and held high through completion:
  - the first dump is unaffected;
  - a second dump starts only after `busy`=0, on the first cycle `start` is seen in IDLE.
- `rst` asserted during the DATA bits of the second byte:
  - next cycle `uart_tx`=1, `busy`=0, `done` never pulses;
  - a following `start` replays from address 0 correctly.
- Edge cases:
  - `last_addr` changed while `busy` does not alter the dump length;
  - `start` and `rst` asserted together leaves the block in IDLE.
